// File: rtl/triangle_assembler_if.sv
// Bundle between the vertex FIFO, the triangle assembler and the rasterizer.
// master = the assembler side; slave = the FIFO/rasterizer side.
interface triangle_assembler_if;
    logic                i_fifo_empty;
    logic                o_fifo_rd_en;
    logic [31:0]         i_x, i_y, i_u, i_v;
    logic [7:0]          i_z;
    logic                i_flush;
    logic                o_tri_valid;
    logic                i_tri_ready;
    logic signed [15:0]  o_x0, o_y0, o_x1, o_y1, o_x2, o_y2;
    logic [7:0]          o_z0, o_z1, o_z2;
    logic [31:0]         o_u0, o_v0, o_u1, o_v1, o_u2, o_v2;
    logic signed [34:0]  o_area;
    logic [9:0]          o_min_x, o_max_x, o_min_y, o_max_y;
    logic [15:0]         o_tri_count, o_cull_count;

    modport master (
        input  i_fifo_empty, i_x, i_y, i_z, i_u, i_v, i_flush, i_tri_ready,
        output o_fifo_rd_en, o_tri_valid,
        output o_x0, o_y0, o_x1, o_y1, o_x2, o_y2, o_z0, o_z1, o_z2,
        output o_u0, o_v0, o_u1, o_v1, o_u2, o_v2,
        output o_area, o_min_x, o_max_x, o_min_y, o_max_y, o_tri_count, o_cull_count
    );

    modport slave (
        output i_fifo_empty, i_x, i_y, i_z, i_u, i_v, i_flush, i_tri_ready,
        input  o_fifo_rd_en, o_tri_valid,
        input  o_x0, o_y0, o_x1, o_y1, o_x2, o_y2, o_z0, o_z1, o_z2,
        input  o_u0, o_v0, o_u1, o_v1, o_u2, o_v2,
        input  o_area, o_min_x, o_max_x, o_min_y, o_max_y, o_tri_count, o_cull_count
    );
endinterface

// File: rtl/triangle_assembler.sv
// Pops vertices from the vertex FIFO, groups them in threes, computes doubled area and
// clamped bbox, culls degenerate/back-facing/off-screen triangles and hands survivors on.
module triangle_assembler #(
    parameter int SCREEN_W  = 320,
    parameter int SCREEN_H  = 240,
    parameter bit CULL_BACK = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    triangle_assembler_if.master  bus
);
    localparam logic signed [15:0] W_LIM = 16'(SCREEN_W);
    localparam logic signed [15:0] H_LIM = 16'(SCREEN_H);
    localparam logic signed [15:0] W_MAX = 16'(SCREEN_W - 1);
    localparam logic signed [15:0] H_MAX = 16'(SCREEN_H - 1);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_SETUP, S_EMIT} state_t;

    state_t state, state_nxt;
    logic   rd_en;
    logic [1:0] idx;

    logic signed [15:0] sx [3];
    logic signed [15:0] sy [3];
    logic [7:0]         sz [3];
    logic [31:0]        su [3];
    logic [31:0]        sv [3];

    logic signed [16:0] dx1, dy1, dx2, dy2;
    logic signed [34:0] area;
    logic signed [15:0] min_x, max_x, min_y, max_y;
    logic               cull, swap;

    function automatic logic signed [15:0] min3(input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [15:0] max3(input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [9:0] clamp(input logic signed [15:0] v, input logic signed [15:0] hi);
        logic signed [15:0] r;
        r = (v < 0) ? 16'sd0 : ((v > hi) ? hi : v);
        return r[9:0];
    endfunction

    // Setup math is purely combinational off the slots; it is only consumed in S_SETUP.
    always_comb begin
        dx1   = {sx[1][15], sx[1]} - {sx[0][15], sx[0]};
        dy1   = {sy[1][15], sy[1]} - {sy[0][15], sy[0]};
        dx2   = {sx[2][15], sx[2]} - {sx[0][15], sx[0]};
        dy2   = {sy[2][15], sy[2]} - {sy[0][15], sy[0]};
        area  = 35'(dx1) * 35'(dy2) - 35'(dx2) * 35'(dy1);
        min_x = min3(sx[0], sx[1], sx[2]);
        max_x = max3(sx[0], sx[1], sx[2]);
        min_y = min3(sy[0], sy[1], sy[2]);
        max_y = max3(sy[0], sy[1], sy[2]);
        swap  = (area < 0);
        cull  = (area == 0) || (swap && CULL_BACK) ||
                (max_x < 0) || (min_x >= W_LIM) || (max_y < 0) || (min_y >= H_LIM);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        unique case (state)
            S_FETCH: if (!i_rst && !bus.i_flush && !bus.i_fifo_empty) begin
                rd_en     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT:  state_nxt = (bus.i_flush || idx != 2'd2) ? S_FETCH : S_SETUP;
            S_SETUP: state_nxt = (bus.i_flush || cull) ? S_FETCH : S_EMIT;
            S_EMIT:  if (bus.o_tri_valid && bus.i_tri_ready) state_nxt = S_FETCH;
            default: state_nxt = S_FETCH;
        endcase
    end

    assign bus.o_fifo_rd_en = rd_en;

    // NOTE: vertex slots are not reset; a triangle is only formed after all three are rewritten.
    always_ff @(posedge i_clk) begin
        if (state == S_WAIT && !bus.i_flush) begin
            sx[idx] <= bus.i_x[31:16];
            sy[idx] <= bus.i_y[31:16];
            sz[idx] <= bus.i_z;
            su[idx] <= bus.i_u;
            sv[idx] <= bus.i_v;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx              <= 2'd0;
            bus.o_tri_valid  <= 1'b0;
            bus.o_x0 <= '0; bus.o_y0 <= '0; bus.o_x1 <= '0;
            bus.o_y1 <= '0; bus.o_x2 <= '0; bus.o_y2 <= '0;
            bus.o_z0 <= '0; bus.o_z1 <= '0; bus.o_z2 <= '0;
            bus.o_u0 <= '0; bus.o_v0 <= '0; bus.o_u1 <= '0;
            bus.o_v1 <= '0; bus.o_u2 <= '0; bus.o_v2 <= '0;
            bus.o_area       <= '0;
            bus.o_min_x <= '0; bus.o_max_x <= '0; bus.o_min_y <= '0; bus.o_max_y <= '0;
            bus.o_tri_count  <= '0;
            bus.o_cull_count <= '0;
        end else begin
            unique case (state)
                S_FETCH: if (bus.i_flush) idx <= 2'd0;
                S_WAIT: begin
                    if (bus.i_flush)        idx <= 2'd0;
                    else if (idx == 2'd2)   idx <= 2'd0;
                    else                    idx <= idx + 2'd1;
                end
                S_SETUP: if (!bus.i_flush) begin
                    if (cull) begin
                        bus.o_cull_count <= bus.o_cull_count + 16'd1;
                    end else begin
                        // Winding fix-up: swapping v1/v2 flips the sign of the area.
                        bus.o_x0 <= sx[0];
                        bus.o_y0 <= sy[0];
                        bus.o_z0 <= sz[0];
                        bus.o_u0 <= su[0];
                        bus.o_v0 <= sv[0];
                        bus.o_x1 <= swap ? sx[2] : sx[1];
                        bus.o_y1 <= swap ? sy[2] : sy[1];
                        bus.o_z1 <= swap ? sz[2] : sz[1];
                        bus.o_u1 <= swap ? su[2] : su[1];
                        bus.o_v1 <= swap ? sv[2] : sv[1];
                        bus.o_x2 <= swap ? sx[1] : sx[2];
                        bus.o_y2 <= swap ? sy[1] : sy[2];
                        bus.o_z2 <= swap ? sz[1] : sz[2];
                        bus.o_u2 <= swap ? su[1] : su[2];
                        bus.o_v2 <= swap ? sv[1] : sv[2];
                        bus.o_area  <= swap ? -area : area;
                        bus.o_min_x <= clamp(min_x, W_MAX);
                        bus.o_max_x <= clamp(max_x, W_MAX);
                        bus.o_min_y <= clamp(min_y, H_MAX);
                        bus.o_max_y <= clamp(max_y, H_MAX);
                        bus.o_tri_valid <= 1'b1;
                    end
                end
                S_EMIT: if (bus.o_tri_valid && bus.i_tri_ready) begin
                    bus.o_tri_valid <= 1'b0;
                    bus.o_tri_count <= bus.o_tri_count + 16'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_triangle_assembler.sv
// Bench for triangle_assembler: one CULL_BACK=0 and one CULL_BACK=1 instance fed the same
// vertex stream, each with its own FIFO model, checked against a triangle-level scoreboard.
module tb_triangle_assembler;
    localparam int SW = 320;
    localparam int SH = 240;

    typedef struct packed {
        logic [31:0] x, y;
        logic [7:0]  z;
        logic [31:0] u, v;
    } word_t;

    typedef struct packed {
        logic [15:0] x0, y0, x1, y1, x2, y2;
        logic [7:0]  z0, z1, z2;
        logic [31:0] u0, v0, u1, v1, u2, v2;
        logic [34:0] area;
        logic [9:0]  mnx, mxx, mny, mxy;
    } tri_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic ready = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    triangle_assembler_if tif0 ();
    triangle_assembler_if tif1 ();

    assign tif0.i_flush = flush;
    assign tif1.i_flush = flush;
    assign tif0.i_tri_ready = ready;
    assign tif1.i_tri_ready = ready;

    triangle_assembler #(.SCREEN_W(SW), .SCREEN_H(SH), .CULL_BACK(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(tif0));
    triangle_assembler #(.SCREEN_W(SW), .SCREEN_H(SH), .CULL_BACK(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(tif1));

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- FIFO models ----------------
    word_t q0[$], q1[$];
    word_t w0, w1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tif0.o_fifo_rd_en) begin
            check("pop0_has_data", longint'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                w0 = q0.pop_front();
                tif0.i_x <= w0.x; tif0.i_y <= w0.y; tif0.i_z <= w0.z;
                tif0.i_u <= w0.u; tif0.i_v <= w0.v;
            end
        end
        if (tif1.o_fifo_rd_en) begin
            check("pop1_has_data", longint'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                w1 = q1.pop_front();
                tif1.i_x <= w1.x; tif1.i_y <= w1.y; tif1.i_z <= w1.z;
                tif1.i_u <= w1.u; tif1.i_v <= w1.v;
            end
        end
        tif0.i_fifo_empty <= (q0.size() == 0);
        tif1.i_fifo_empty <= (q1.size() == 0);
    end

    // ---------------- Triangle-level model ----------------
    int          pend_x[3], pend_y[3], pend_z[3];
    logic [31:0] pend_u[3], pend_v[3];
    int          npend = 0;
    int          seq = 0;
    tri_t        expq0[$], expq1[$];
    int          exp_tri[2] = '{0, 0};
    int          exp_cull[2] = '{0, 0};

    function automatic int imin3(input int a, b, c);
        int m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic int imax3(input int a, b, c);
        int m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [9:0] iclamp(input int v, input int hi);
        int r = (v < 0) ? 0 : ((v > hi) ? hi : v);
        return r[9:0];
    endfunction

    task automatic model_tri(input bit cb);
        longint ar;
        int i1, i2, mnx, mxx, mny, mxy;
        tri_t t;
        ar = longint'(pend_x[1] - pend_x[0]) * (pend_y[2] - pend_y[0])
           - longint'(pend_x[2] - pend_x[0]) * (pend_y[1] - pend_y[0]);
        mnx = imin3(pend_x[0], pend_x[1], pend_x[2]);
        mxx = imax3(pend_x[0], pend_x[1], pend_x[2]);
        mny = imin3(pend_y[0], pend_y[1], pend_y[2]);
        mxy = imax3(pend_y[0], pend_y[1], pend_y[2]);
        if (ar == 0 || (ar < 0 && cb) || mxx < 0 || mnx >= SW || mxy < 0 || mny >= SH) begin
            exp_cull[cb]++;
            return;
        end
        i1 = 1; i2 = 2;
        if (ar < 0) begin i1 = 2; i2 = 1; ar = -ar; end
        t.x0 = pend_x[0][15:0];  t.y0 = pend_y[0][15:0];  t.z0 = pend_z[0][7:0];
        t.x1 = pend_x[i1][15:0]; t.y1 = pend_y[i1][15:0]; t.z1 = pend_z[i1][7:0];
        t.x2 = pend_x[i2][15:0]; t.y2 = pend_y[i2][15:0]; t.z2 = pend_z[i2][7:0];
        t.u0 = pend_u[0];  t.v0 = pend_v[0];
        t.u1 = pend_u[i1]; t.v1 = pend_v[i1];
        t.u2 = pend_u[i2]; t.v2 = pend_v[i2];
        t.area = ar[34:0];
        t.mnx = iclamp(mnx, SW - 1); t.mxx = iclamp(mxx, SW - 1);
        t.mny = iclamp(mny, SH - 1); t.mxy = iclamp(mxy, SH - 1);
        exp_tri[cb]++;
        if (cb) expq1.push_back(t);
        else    expq0.push_back(t);
    endtask

    task automatic push(input int px, input int py);
        word_t w;
        seq++;
        w.x = {px[15:0], 16'h8000};
        w.y = {py[15:0], 16'h4000};
        w.z = 8'(seq * 7);
        w.u = 32'hA000_0000 | 32'(seq);
        w.v = 32'h5000_0000 | 32'(seq * 3);
        q0.push_back(w);
        q1.push_back(w);
        pend_x[npend] = px;  pend_y[npend] = py; pend_z[npend] = int'(w.z);
        pend_u[npend] = w.u; pend_v[npend] = w.v;
        npend++;
        if (npend == 3) begin
            npend = 0;
            model_tri(1'b0);
            model_tri(1'b1);
        end
    endtask

    // ---------------- Compare process ----------------
    tri_t snap[2];
    bit   hold[2] = '{1'b0, 1'b0};

    function automatic tri_t grab0();
        tri_t t;
        t.x0 = tif0.o_x0; t.y0 = tif0.o_y0; t.x1 = tif0.o_x1; t.y1 = tif0.o_y1;
        t.x2 = tif0.o_x2; t.y2 = tif0.o_y2; t.z0 = tif0.o_z0; t.z1 = tif0.o_z1; t.z2 = tif0.o_z2;
        t.u0 = tif0.o_u0; t.v0 = tif0.o_v0; t.u1 = tif0.o_u1; t.v1 = tif0.o_v1;
        t.u2 = tif0.o_u2; t.v2 = tif0.o_v2; t.area = tif0.o_area;
        t.mnx = tif0.o_min_x; t.mxx = tif0.o_max_x; t.mny = tif0.o_min_y; t.mxy = tif0.o_max_y;
        return t;
    endfunction

    function automatic tri_t grab1();
        tri_t t;
        t.x0 = tif1.o_x0; t.y0 = tif1.o_y0; t.x1 = tif1.o_x1; t.y1 = tif1.o_y1;
        t.x2 = tif1.o_x2; t.y2 = tif1.o_y2; t.z0 = tif1.o_z0; t.z1 = tif1.o_z1; t.z2 = tif1.o_z2;
        t.u0 = tif1.o_u0; t.v0 = tif1.o_v0; t.u1 = tif1.o_u1; t.v1 = tif1.o_v1;
        t.u2 = tif1.o_u2; t.v2 = tif1.o_v2; t.area = tif1.o_area;
        t.mnx = tif1.o_min_x; t.mxx = tif1.o_max_x; t.mny = tif1.o_min_y; t.mxy = tif1.o_max_y;
        return t;
    endfunction

    task automatic check_tri(input string n, input tri_t g, input tri_t e);
        check({n, "_x0"}, g.x0, e.x0); check({n, "_y0"}, g.y0, e.y0);
        check({n, "_x1"}, g.x1, e.x1); check({n, "_y1"}, g.y1, e.y1);
        check({n, "_x2"}, g.x2, e.x2); check({n, "_y2"}, g.y2, e.y2);
        check({n, "_z0"}, g.z0, e.z0); check({n, "_z1"}, g.z1, e.z1); check({n, "_z2"}, g.z2, e.z2);
        check({n, "_u0"}, g.u0, e.u0); check({n, "_v0"}, g.v0, e.v0);
        check({n, "_u1"}, g.u1, e.u1); check({n, "_v1"}, g.v1, e.v1);
        check({n, "_u2"}, g.u2, e.u2); check({n, "_v2"}, g.v2, e.v2);
        check({n, "_area"}, g.area, e.area);
        check({n, "_min_x"}, g.mnx, e.mnx); check({n, "_max_x"}, g.mxx, e.mxx);
        check({n, "_min_y"}, g.mny, e.mny); check({n, "_max_y"}, g.mxy, e.mxy);
    endtask

    task automatic score(input int k, input tri_t got, input logic vld);
        int   n;
        tri_t e;
        if (!vld) begin
            hold[k] = 1'b0;
            return;
        end
        if (hold[k]) check_tri($sformatf("dut%0d_hold", k), got, snap[k]);
        if (ready) begin
            n = (k == 0) ? expq0.size() : expq1.size();
            check($sformatf("dut%0d_tri_expected", k), longint'(n > 0), 1);
            if (n > 0) begin
                e = (k == 0) ? expq0.pop_front() : expq1.pop_front();
                check_tri($sformatf("dut%0d_tri", k), got, e);
            end
            hold[k] = 1'b0;
        end else begin
            snap[k] = got;
            hold[k] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            score(0, grab0(), tif0.o_tri_valid);
            score(1, grab1(), tif1.o_tri_valid);
        end
    end

    // ---------------- Directed sequence ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_rd(input bit k, output int t);
        t = -1;
        for (int b = 0; b < 40; b++) begin
            if (k ? tif1.o_fifo_rd_en : tif0.o_fifo_rd_en) begin t = cyc; break; end
            step();
        end
        check("wait_rd_seen", longint'(t >= 0), 1);
    endtask

    task automatic wait_valid(input bit k, output int t);
        t = -1;
        for (int b = 0; b < 60; b++) begin
            if (k ? tif1.o_tri_valid : tif0.o_tri_valid) begin t = cyc; break; end
            step();
        end
        check("wait_valid_seen", longint'(t >= 0), 1);
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int b = 0; b < 400 && quiet < 8; b++) begin
            step();
            if (q0.size() == 0 && q1.size() == 0 && !tif0.o_tri_valid && !tif1.o_tri_valid)
                quiet++;
            else
                quiet = 0;
        end
        check("idle_reached", longint'(quiet >= 8), 1);
    endtask

    task automatic check_counts(input string n, input int t0, c0, t1, c1);
        check({n, "_tri0"},  tif0.o_tri_count,  t0);
        check({n, "_cull0"}, tif0.o_cull_count, c0);
        check({n, "_tri1"},  tif1.o_tri_count,  t1);
        check({n, "_cull1"}, tif1.o_cull_count, c1);
        check({n, "_model_tri0"},  tif0.o_tri_count,  exp_tri[0]);
        check({n, "_model_cull1"}, tif1.o_cull_count, exp_cull[1]);
    endtask

    initial begin
        int t0, t1, pops;
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, pops;
        rst = 1'b1; flush = 1'b0; ready = 1'b1;
        repeat (3) step();
        check("rst_valid0", tif0.o_tri_valid, 0);
        check("rst_valid1", tif1.o_tri_valid, 0);
        check("rst_rd_en1", tif1.o_fifo_rd_en, 0);
        check("rst_area1",  tif1.o_area, 0);
        check("rst_x0_1",   tif1.o_x0, 0);
        check("rst_min_x1", tif1.o_min_x, 0);
        check_counts("rst", 0, 0, 0, 0);
        rst = 1'b0;
        step();

        // CCW triangle, FIFO stays non-empty once filled
        push(10, 10); push(50, 10); push(10, 40);
        wait_rd(1'b1, t0);
        wait_valid(1'b1, t1);
        check("ccw_latency", t1 - t0, 7);
        check("ccw_area",  tif1.o_area, 1200);
        check("ccw_min_x", tif1.o_min_x, 10);
        check("ccw_max_x", tif1.o_max_x, 50);
        check("ccw_min_y", tif1.o_min_y, 10);
        check("ccw_max_y", tif1.o_max_y, 40);
        wait_idle();
        check_counts("ccw", 1, 0, 1, 0);

        // Clockwise: culled with CULL_BACK=1, swapped with CULL_BACK=0
        push(10, 10); push(10, 40); push(50, 10);
        wait_valid(1'b0, t1);
        check("swap_x1", tif0.o_x1, 50);
        check("swap_y1", tif0.o_y1, 10);
        check("swap_x2", tif0.o_x2, 10);
        check("swap_y2", tif0.o_y2, 40);
        check("swap_area", tif0.o_area, 1200);
        wait_idle();
        check_counts("backface", 2, 0, 1, 1);

        // Degenerate, off-screen left, off-screen above
        push(0, 0);     push(5, 5);     push(9, 9);
        push(-30, 0);   push(-5, 0);    push(-30, 20);
        push(100, -50); push(150, -50); push(100, -10);
        wait_idle();
        check_counts("cull", 2, 3, 1, 4);

        // Screen clamp under backpressure, a second triangle queued behind it
        ready = 1'b0;
        push(-20, -20); push(400, -20); push(-20, 300);
        push(100, 100); push(120, 100); push(100, 130);
        wait_valid(1'b1, t1);
        check("clamp_x0",    tif1.o_x0, -20);
        check("clamp_area",  tif1.o_area, 134400);
        check("clamp_min_x", tif1.o_min_x, 0);
        check("clamp_max_x", tif1.o_max_x, 319);
        check("clamp_min_y", tif1.o_min_y, 0);
        check("clamp_max_y", tif1.o_max_y, 239);
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            pops += int'(tif0.o_fifo_rd_en) + int'(tif1.o_fifo_rd_en);
            check("bp_valid1", tif1.o_tri_valid, 1);
        end
        check("bp_no_pops", pops, 0);
        ready = 1'b1;
        step();
        check("acc_valid0_drop", tif0.o_tri_valid, 0);
        check("acc_valid1_drop", tif1.o_tri_valid, 0);
        check("acc_rd_en0", tif0.o_fifo_rd_en, 1);
        check("acc_rd_en1", tif1.o_fifo_rd_en, 1);
        wait_idle();
        check_counts("clamp", 4, 3, 3, 4);

        // Flush discards a partial triangle; pops are held off while flush is high
        push(1, 1); push(2, 2);
        wait_idle();
        flush = 1'b1;
        npend = 0;
        push(20, 20); push(60, 20); push(20, 50);
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_rd_en0", tif0.o_fifo_rd_en, 0);
            check("flush_rd_en1", tif1.o_fifo_rd_en, 0);
        end
        flush = 1'b0;
        wait_valid(1'b1, t1);
        check("flush_x0", tif1.o_x0, 20);
        check("flush_y0", tif1.o_y0, 20);
        check("flush_x1", tif1.o_x1, 60);
        wait_idle();
        check_counts("flush", 5, 3, 4, 4);

        // Reset with a partial triangle gathered
        push(5, 5); push(6, 6);
        wait_idle();
        rst = 1'b1;
        npend = 0;
        exp_tri = '{0, 0};
        exp_cull = '{0, 0};
        step();
        check("mrst_valid1", tif1.o_tri_valid, 0);
        check("mrst_area0",  tif0.o_area, 0);
        check("mrst_x0_0",   tif0.o_x0, 0);
        check("mrst_max_x1", tif1.o_max_x, 0);
        check_counts("mrst", 0, 0, 0, 0);
        rst = 1'b0;
        step();
        push(30, 30); push(70, 30); push(30, 60);
        wait_idle();
        check_counts("recover", 1, 0, 1, 0);

        check("sb_drain0", expq0.size(), 0);
        check("sb_drain1", expq1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/triangle_assembler.md
# triangle_assembler

Consumer end of the vertex FIFO. Pops screen-space vertices (Q16.16 X/Y, 8-bit depth, Q16.16 U/V) written by the geometry stage and groups every three into a triangle. For each triangle it computes the integer signed doubled area and a screen-clamped bounding box, culls degenerate, back-facing and fully off-screen triangles, and presents survivors to the rasterizer over a valid/ready handshake.

## Interface
- SCREEN_W, 320, screen width in pixels; bbox X clamp bound.
- SCREEN_H, 240, screen height in pixels; bbox Y clamp bound.
- CULL_BACK, 1, 1: drop area<0; 0: keep area<0 after swapping v1 and v2.
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_fifo_empty  in  1  vertex FIFO empty.
- o_fifo_rd_en  out  1  pop strobe; data valid one cycle later.
- i_x, i_y  in  32 each  vertex screen position, Q16.16; integer pixel = bits [31:16], signed.
- i_z  in  8  vertex depth.
- i_u, i_v  in  32 each  texture coordinates, Q16.16, passed through.
- i_flush  in  1  discard any partially gathered triangle.
- o_tri_valid  out  1  triangle available.
- i_tri_ready  in  1  rasterizer accepts.
- o_x0, o_y0, o_x1, o_y1, o_x2, o_y2  out  16 each  signed integer vertex pixels.
- o_z0, o_z1, o_z2  out  8 each  depths.
- o_u0, o_v0, o_u1, o_v1, o_u2, o_v2  out  32 each  texture coordinates.
- o_area  out  35  signed doubled area; always >0 when o_tri_valid.
- o_min_x, o_max_x, o_min_y, o_max_y  out  10 each  clamped bounding box.
- o_tri_count, o_cull_count  out  16 each  emitted / culled triangle counters; wrap 65535->0.

## Operation
- States: S_FETCH, S_WAIT, S_SETUP, S_EMIT. Reset state: S_FETCH, vertex index 0.
- Reset values: every output 0, including counters.
- S_FETCH: when !i_fifo_empty, assert o_fifo_rd_en for one cycle and go to S_WAIT. When empty, stay in S_FETCH with rd_en low.
- S_WAIT: capture i_x[31:16], i_y[31:16], i_z, i_u, i_v into slot[index]. If index==2, go to S_SETUP with index 0. Otherwise increment index and go to S_FETCH.
- S_SETUP (one cycle):
  - Operands: dx1=x1-x0, dy1=y1-y0, dx2=x2-x0, dy2=y2-y0, each 17-bit signed.
  - area = dx1*dy2 - dx2*dy1, 35-bit signed, no truncation.
  - Unclamped bbox = min/max of the three signed ints.
  - Cull if any of:
    - area==0;
    - area<0 and CULL_BACK=1;
    - max_x<0, min_x>=SCREEN_W, max_y<0, or min_y>=SCREEN_H.
  - On cull: increment o_cull_count, go to S_FETCH.
  - If area<0 and CULL_BACK=0: swap slots 1 and 2 and negate area.
  - Otherwise register outputs: bbox clamped to [0, SCREEN_W-1] / [0, SCREEN_H-1]; o_tri_valid<=1; go to S_EMIT.
- S_EMIT: hold all triangle outputs stable. On o_tri_valid&&i_tri_ready: drop o_tri_valid next cycle, increment o_tri_count, go to S_FETCH.
- i_flush:
  - In S_FETCH, S_WAIT, S_SETUP: index<=0, go to S_FETCH; any word returning from an issued pop is discarded; no counter changes.
  - In S_EMIT: ignored; the emitted triangle completes normally.
  - When asserted in S_FETCH, o_fifo_rd_en is suppressed that cycle.
- Reset mid-operation: partial triangle lost, outputs return to reset values next cycle.

## Timing
- One vertex per 2 cycles.
- First pop at T: pops at T, T+2, T+4; captures at T+3, T+5; S_SETUP at T+6; o_tri_valid high at T+7.
- Empty FIFO inserts stall cycles in S_FETCH only; at most one pop is outstanding.
- Acceptance at cycle A: o_tri_valid low at A+1; next pop no earlier than A+1.
- Culled triangle: no valid pulse; next pop at T+7.
- Backpressure: outputs must not change while o_tri_valid && !i_tri_ready.

## Test plan
- CCW emit: vertices (10,10), (50,10), (10,40) in Q16.16; FIFO never empty; ready=1.
  -> o_tri_valid at T+7; area=1200; bbox x 10..50, y 10..40; o_tri_count=1.
- Back-face cull: vertices (10,10), (10,40), (50,10); CULL_BACK=1.
  -> no valid; o_cull_count=1.
- Swap path: same triangle with CULL_BACK=0.
  -> emits with v1=(50,10), v2=(10,40), area=+1200.
- Degenerate and off-screen: collinear (0,0), (5,5), (9,9) -> culled. Triangle with all x in [-30,-5] -> culled.
- Clamp and backpressure: vertices (-20,-20), (400,-20), (-20,300).
  -> bbox 0..319, 0..239.
  - Hold ready=0 for 10 cycles -> outputs stable, no pops.
  - Raise ready -> accepted; rd_en resumes next cycle.
- Flush: push 2 vertices, assert i_flush, then push 3 new vertices.
  -> emitted triangle uses only the last 3 vertices. Counters unchanged by the flush.
